// File: rtl/sprite_datapath.sv
// -----------------------------------------------------------------------------
// sprite_datapath
//
// Datapath that sits directly behind the game control FSM. On request it
// sweeps a BOX_W x BOX_H rectangle, row-major from the top-left corner, into
// the VGA adapter's write port. It returns a one-cycle done pulse and owns the
// sprite position/velocity registers, which bounce off the screen edges.
//
// Handshake: a sweep request is the level datapath_en, looked at only in IDLE.
// Once accepted, one pixel is emitted per cycle in which move_en is high
// (plot=1 marks a valid pixel). move_en low stalls the sweep on the current
// pixel. done is a single-cycle pulse after the last pixel, and datapath_en
// is ignored while done is high.
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   datapath_en  - start a sweep (sampled in IDLE)
//   op           - 00 draw, 01 erase, 1x reserved (completes with no plot)
//   load_coord   - one-cycle pulse, advance position one step (IDLE only)
//   move_en      - sweep advance enable
//   x_out, y_out - VGA pixel coordinate
//   colour       - VGA pixel colour
//   plot         - VGA write strobe
//   done         - sweep complete pulse
//   touch_edge   - sprite rectangle touches any screen edge
// -----------------------------------------------------------------------------
module sprite_datapath #(
    parameter int          SCREEN_W  = 160,
    parameter int          SCREEN_H  = 120,
    parameter int          BOX_W     = 4,
    parameter int          BOX_H     = 4,
    parameter logic [7:0]  X_INIT    = 8'd78,
    parameter logic [6:0]  Y_INIT    = 7'd58,
    parameter logic [2:0]  FG_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       datapath_en,
    input  logic [1:0] op,
    input  logic       load_coord,
    input  logic       move_en,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic       touch_edge
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest legal top-left position on each axis.
    localparam logic [7:0] X_MAX   = 8'(SCREEN_W - BOX_W);
    localparam logic [6:0] Y_MAX   = 7'(SCREEN_H - BOX_H);
    localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
    localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       dir_x;   // 0 = increasing
    logic       dir_y;   // 0 = increasing
    logic [3:0] cx;
    logic [3:0] cy;
    logic [1:0] op_q;

    logic       advance;
    logic       last_pixel;

    assign advance    = (state == SWEEP) && move_en;
    assign last_pixel = (cx == CX_LAST) && (cy == CY_LAST);

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pos_x <= X_INIT;
            pos_y <= Y_INIT;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
            cx    <= 4'd0;
            cy    <= 4'd0;
            op_q  <= 2'b00;
        end else begin
            state <= state_next;

            if (state == IDLE) begin
                if (datapath_en && !op[1]) begin
                    op_q <= op;
                    cx   <= 4'd0;
                    cy   <= 4'd0;
                end

                // Position stepping happens only between sweeps so a sprite
                // is never drawn at one place and erased at another. At an
                // edge the step both reverses direction and moves one pixel
                // back, so the position never sits still on a pulse.
                if (load_coord) begin
                    if (!dir_x) begin
                        if (pos_x == X_MAX) begin
                            dir_x <= 1'b1;
                            pos_x <= pos_x - 8'd1;
                        end else begin
                            pos_x <= pos_x + 8'd1;
                        end
                    end else begin
                        if (pos_x == 8'd0) begin
                            dir_x <= 1'b0;
                            pos_x <= pos_x + 8'd1;
                        end else begin
                            pos_x <= pos_x - 8'd1;
                        end
                    end

                    if (!dir_y) begin
                        if (pos_y == Y_MAX) begin
                            dir_y <= 1'b1;
                            pos_y <= pos_y - 7'd1;
                        end else begin
                            pos_y <= pos_y + 7'd1;
                        end
                    end else begin
                        if (pos_y == 7'd0) begin
                            dir_y <= 1'b0;
                            pos_y <= pos_y + 7'd1;
                        end else begin
                            pos_y <= pos_y - 7'd1;
                        end
                    end
                end
            end else if (advance) begin
                if (cx == CX_LAST) begin
                    cx <= 4'd0;
                    cy <= last_pixel ? 4'd0 : cy + 4'd1;
                end else begin
                    cx <= cx + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (datapath_en) begin
                    // Reserved ops complete immediately with no pixels.
                    state_next = op[1] ? DONE : SWEEP;
                end
            end
            SWEEP: begin
                if (advance && last_pixel) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, combinational from registered state
    // ------------------------------------------------------------------
    always_comb begin
        x_out  = pos_x;
        y_out  = pos_y;
        colour = BG_COLOUR;
        plot   = 1'b0;
        done   = 1'b0;
        if (advance) begin
            plot   = 1'b1;
            x_out  = pos_x + {4'd0, cx};
            y_out  = pos_y + {3'd0, cy};
            colour = (op_q == 2'b00) ? FG_COLOUR : BG_COLOUR;
        end
        if (state == DONE) begin
            done = 1'b1;
        end
    end

    assign touch_edge = (pos_x == 8'd0) || (pos_x == X_MAX) ||
                        (pos_y == 7'd0) || (pos_y == Y_MAX);

endmodule

// File: tb/tb_sprite_datapath.sv
// -----------------------------------------------------------------------------
// tb_sprite_datapath
//
// Bench for sprite_datapath with default parameters (160x120 screen, 4x4 box,
// start at (78,58)). Pixels are predicted into a queue when a sweep is
// launched and checked in order by a monitor whenever plot is high. Position
// stepping is checked against a table of {pulse count, x, y, touch_edge}.
// -----------------------------------------------------------------------------
module tb_sprite_datapath;

    logic       clk;
    logic       reset;
    logic       datapath_en;
    logic [1:0] op;
    logic       load_coord;
    logic       move_en;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       done;
    logic       touch_edge;

    int n_cmp = 0;
    int n_bad = 0;
    int plot_seen = 0;

    // Expected pixel = {x[7:0], y[6:0], colour[2:0]}
    logic [17:0] exp_q[$];

    typedef struct {
        int         pulses;
        logic [7:0] x;
        logic [6:0] y;
        logic       touch;
    } pos_vec_t;

    pos_vec_t pos_vec[6];

    sprite_datapath dut (
        .clk         (clk),
        .reset       (reset),
        .datapath_en (datapath_en),
        .op          (op),
        .load_coord  (load_coord),
        .move_en     (move_en),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour      (colour),
        .plot        (plot),
        .done        (done),
        .touch_edge  (touch_edge)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel monitor: every plot must match the next predicted pixel.
    always @(negedge clk) begin
        if (!reset && plot) begin
            plot_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected no plot",
                         x_out, y_out, colour);
            end else begin
                check("pixel", {14'd0, x_out, y_out, colour}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_box(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back({bx + 8'(c), by + 7'(r), col});
            end
        end
    endtask

    // Launch one sweep and follow it to its done pulse. The pause, when
    // requested, drops move_en for pause_len cycles after the 6th pixel.
    task automatic sweep(input logic [1:0] o, input int pause_len, input logic lc_start,
                         input logic lc_mid, input logic [7:0] bx, input logic [6:0] by,
                         input int exp_done);
        int seen0;
        int done_at;
        seen0 = plot_seen;
        if (!o[1]) push_box(bx, by, (o == 2'b00) ? 3'b111 : 3'b000);
        @(posedge clk); #1;
        datapath_en = 1'b1;
        op          = o;
        load_coord  = lc_start;
        move_en     = 1'b1;
        @(posedge clk); #1;
        datapath_en = 1'b0;
        load_coord  = 1'b0;
        done_at = 0;
        for (int i = 1; i <= 80 && done_at == 0; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            move_en    = !(pause_len > 0 && i > 6 && i <= 6 + pause_len);
            load_coord = lc_mid && (i == 3);
            @(negedge clk);
            if (done) done_at = i;
        end
        check("done_cycle", done_at, exp_done);
        check("plot_count", plot_seen - seen0, o[1] ? 0 : 16);
        @(posedge clk); #1;
        move_en    = 1'b1;
        load_coord = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 0);
    endtask

    task automatic check_pos(input string name, input logic [7:0] x, input logic [6:0] y,
                             input logic t);
        check({name, "_x"}, {24'd0, x_out}, {24'd0, x});
        check({name, "_y"}, {25'd0, y_out}, {25'd0, y});
        check({name, "_touch"}, {31'd0, touch_edge}, {31'd0, t});
    endtask

    task automatic pulse_load();
        @(posedge clk); #1;
        load_coord = 1'b1;
        @(posedge clk); #1;
        load_coord = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int pulses;
        int seen0;
        int done_count;

        // Cumulative load_coord pulses from (78,58), both directions increasing.
        // y reaches 116 after 58 pulses and turns back; x reaches 156 after 78.
        pos_vec[0] = '{1,  8'd79,  7'd59,  1'b0};
        pos_vec[1] = '{20, 8'd98,  7'd78,  1'b0};
        pos_vec[2] = '{58, 8'd136, 7'd116, 1'b1};
        pos_vec[3] = '{59, 8'd137, 7'd115, 1'b0};
        pos_vec[4] = '{78, 8'd156, 7'd96,  1'b1};
        pos_vec[5] = '{80, 8'd154, 7'd94,  1'b0};

        reset       = 1'b1;
        datapath_en = 1'b0;
        op          = 2'b00;
        load_coord  = 1'b0;
        move_en     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_plot", {31'd0, plot}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_colour", {29'd0, colour}, 0);
        check_pos("rst", 8'd78, 7'd58, 1'b0);

        // Draw, then erase right after the done pulse, then a paused draw
        sweep(2'b00, 0, 1'b0, 1'b0, 8'd78, 7'd58, 17);
        sweep(2'b01, 0, 1'b0, 1'b0, 8'd78, 7'd58, 17);
        sweep(2'b00, 5, 1'b0, 1'b0, 8'd78, 7'd58, 22);

        // Position stepping and edge bounce
        pulses = 0;
        for (int v = 0; v < 6; v++) begin
            while (pulses < pos_vec[v].pulses) begin
                pulse_load();
                pulses++;
            end
            @(negedge clk);
            check_pos($sformatf("bounce%0d", pos_vec[v].pulses),
                      pos_vec[v].x, pos_vec[v].y, pos_vec[v].touch);
        end

        // Load together with start: sweep uses the stepped position (153,93).
        // A load pulse mid-sweep must be ignored.
        sweep(2'b00, 0, 1'b1, 1'b1, 8'd153, 7'd93, 17);
        check_pos("after_sim_load", 8'd153, 7'd93, 1'b0);

        // Reset after the 8th pixel
        seen0 = plot_seen;
        push_box(8'd153, 7'd93, 3'b111);
        @(posedge clk); #1;
        datapath_en = 1'b1;
        op          = 2'b00;
        move_en     = 1'b1;
        @(posedge clk); #1;
        datapath_en = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_plot", {31'd0, plot}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_pixels", plot_seen - seen0, 8);
        check_pos("midrst", 8'd78, 7'd58, 1'b0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        done_count = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_count++;
        end
        check("midrst_no_done", done_count, 0);

        // Direction registers are back to increasing
        pulse_load();
        @(negedge clk);
        check_pos("dir_after_rst", 8'd79, 7'd59, 1'b0);

        // Reserved op: done in the next cycle, no pixels
        sweep(2'b10, 0, 1'b0, 1'b0, 8'd0, 7'd0, 1);

        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_datapath.md
Name: sprite_datapath

Overview:
- Datapath directly downstream of the game control FSM.
- Consumes the FSM's `datapath_en`, `op`, `load_coord` and `move_en`.
- Sweeps a BOX_W x BOX_H sprite rectangle pixel by pixel into the VGA adapter's write port (x, y, colour, plot).
- Returns `done` to the FSM, owns the sprite position/velocity registers with edge bounce, and reports `touch_edge`.

Parameters:
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
BOX_W, 4, sprite width in pixels (1..16)
BOX_H, 4, sprite height in pixels (1..16)
X_INIT, 8'd78, reset x position (must be <= SCREEN_W-BOX_W)
Y_INIT, 7'd58, reset y position (must be <= SCREEN_H-BOX_H)
FG_COLOUR, 3'b111, colour used for draw
BG_COLOUR, 3'b000, colour used for erase

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
datapath_en  in  1  FSM request: start a sweep (level, sampled in IDLE)
op  in  2  00 draw, 01 erase, 1x reserved
load_coord  in  1  one-cycle pulse: advance position one step
move_en  in  1  sweep advance enable; low pauses an in-progress sweep
x_out  out  8  VGA pixel x
y_out  out  7  VGA pixel y
colour  out  3  VGA pixel colour
plot  out  1  VGA write strobe
done  out  1  one-cycle pulse: sweep complete
touch_edge  out  1  sprite rectangle currently touching any screen edge

Behaviour:
- Async reset, active-high. Forces the following regardless of activity; a reset mid-sweep aborts with no further plot:
  - state=IDLE
  - pos_x=X_INIT, pos_y=Y_INIT
  - dir_x=dir_y=0 (0 = increasing)
  - cx=cy=0, op_q=00
- Output values after reset: plot=0, done=0, x_out=X_INIT, y_out=Y_INIT, colour=BG_COLOUR, touch_edge per init position.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - datapath_en=1 with op=00/01: latch op_q, clear cx/cy, go to SWEEP.
  - datapath_en=1 with op=1x: go to DONE directly, no plot.
- SWEEP, move_en=1:
  - plot=1, x_out=pos_x+cx, y_out=pos_y+cy.
  - colour=FG_COLOUR if op_q=00, else BG_COLOUR.
  - At each clock cx increments. At cx=BOX_W-1, cx wraps to 0 and cy increments.
  - At (BOX_W-1, BOX_H-1) go to DONE.
  - Pixel order is row-major from the top-left.
- SWEEP, move_en=0: plot=0; cx, cy and state hold; resumes at the same pixel.
- DONE: done=1, plot=0 for exactly one cycle, then IDLE. `datapath_en` is ignored in DONE, so the FSM's draw->erase transition starts the erase on the following cycle.
- Outside SWEEP: x_out=pos_x, y_out=pos_y, colour=BG_COLOUR, plot=0.
- Latency: with move_en held high and datapath_en sampled at edge k, plot is high for BOX_W*BOX_H cycles after edge k, and done is high in the cycle after the last plot.
- Outputs are combinational from registered state; x/y addition is unsigned, no overflow given the parameter constraints.
- load_coord (acted on in IDLE only; ignored in SWEEP/DONE). Each axis independently:
  - x, dir_x=0: if pos_x==SCREEN_W-BOX_W, set dir_x=1 and pos_x-=1; else pos_x+=1.
  - x, dir_x=1: if pos_x==0, set dir_x=0 and pos_x+=1; else pos_x-=1.
  - y: same rules with SCREEN_H-BOX_H.
  - The position never leaves [0, SCREEN-BOX].
- touch_edge = (pos_x==0) | (pos_x==SCREEN_W-BOX_W) | (pos_y==0) | (pos_y==SCREEN_H-BOX_H). Combinational.
- Simultaneous datapath_en and load_coord in IDLE: both take effect. The sweep uses the updated position, since the sweep's first plot cycle follows the position update edge.

Test Plan:
1. Reset, then release with no activity -> plot=0, done=0, x_out=78, y_out=58, colour=000, touch_edge=0.
2. Draw sweep: pos (78,58), op=00, datapath_en=1, move_en=1 -> 16 plot cycles, colour=111, pixels (78,58),(79,58),(80,58),(81,58),(78,59)...(81,61); done high exactly one cycle after the last plot.
3. Erase sweep: op=01 immediately after done -> 16 plots of the same pixels with colour=000, then one done pulse.
4. Bounce: issue 78 load_coord pulses -> pos_x reaches 156, pos_y reaches 119-3=116... until y hits its edge; the next pulse at x=156 yields pos_x=155, dir_x=1; touch_edge=1 exactly at pos_x=156 or pos_y=116.
5. Pause: drop move_en for 5 cycles after the 6th pixel -> plot=0 during the pause; resumes at pixel 7; done comes 5 cycles later than in scenario 2.
6. Reset mid-sweep after pixel 8 -> plot drops immediately, no done pulse, position back to (78,58). Additionally, op=10 -> done pulses in the cycle after datapath_en is sampled, with zero plot cycles.
